// File: rtl/pcie_symbol_scheduler_pkg.sv
// Shared symbol-select codes, FSM state encoding and K/D classification for the PCIe symbol scheduler.
package pcie_symbol_scheduler_pkg;

    localparam logic [3:0] SEL_TLP = 4'd0;
    localparam logic [3:0] SEL_COM = 4'd1;
    localparam logic [3:0] SEL_PAD = 4'd2;
    localparam logic [3:0] SEL_SKP = 4'd3;
    localparam logic [3:0] SEL_STP = 4'd4;
    localparam logic [3:0] SEL_SDP = 4'd5;
    localparam logic [3:0] SEL_END = 4'd6;
    localparam logic [3:0] SEL_EDB = 4'd7;
    localparam logic [3:0] SEL_FTS = 4'd8;
    localparam logic [3:0] SEL_IDL = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SKP_COM,
        ST_SKP_SKP,
        ST_STP,
        ST_TLP_DATA,
        ST_TLP_END,
        ST_TLP_EDB,
        ST_SDP,
        ST_DLLP_DATA,
        ST_DLLP_END
    } state_e;

    typedef enum logic {
        GRANT_TLP,
        GRANT_DLLP
    } grant_e;

    // Only data bytes (TLP or DLLP payload) travel as D-symbols.
    function automatic logic is_k_sym(input logic [3:0] sel);
        return sel != SEL_TLP;
    endfunction

endpackage

// File: rtl/pcie_symbol_scheduler_skp_timer.sv
// SKP ordered-set request timer: raises skp_pending every SKP_INTERVAL enabled cycles, zero latency.
// No backpressure; an unserved request that is re-raised sets the sticky overrun flag.
module pcie_symbol_scheduler_skp_timer #(
    parameter int SKP_INTERVAL = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic enb_i,
    input  logic skp_take_i,
    output logic skp_pending_o,
    output logic skp_overrun_o
);

    localparam int CW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] CNT_LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (enb_i) begin
            if (cnt_q == CNT_LAST) begin
                // A fresh request always wins over a same-cycle take.
                cnt_d     = '0;
                pending_d = 1'b1;
                overrun_d = overrun_q | pending_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (skp_take_i) begin
                    pending_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign skp_pending_o = pending_q;
    assign skp_overrun_o = overrun_q;

endmodule

// File: rtl/pcie_symbol_scheduler.sv
// PCIe TX symbol scheduler: STP/SDP one cycle after a grant in IDLE, data accepted the cycle after.
// Sources are held off (ready low) outside their data phase; ENB low stalls every register.
module pcie_symbol_scheduler
    import pcie_symbol_scheduler_pkg::*;
#(
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_COUNT    = 3,
    parameter int MAX_TLP_LEN  = 16,
    parameter int DLLP_LEN     = 6
) (
    input  logic       CLK_2MHz,
    input  logic       reset,
    input  logic       ENB,
    input  logic       tlp_valid,
    input  logic       tlp_last,
    output logic       tlp_ready,
    input  logic       dllp_valid,
    output logic       dllp_ready,
    output logic [3:0] CTRL_SEL,
    output logic       SYM_K,
    output logic       tlp_abort,
    output logic       skp_overrun
);

    localparam logic [7:0] SKP_LAST  = 8'(SKP_COUNT - 1);
    localparam logic [7:0] TLP_LAST  = 8'(MAX_TLP_LEN - 1);
    localparam logic [7:0] DLLP_LAST = 8'(DLLP_LEN - 1);

    state_e     state_q;
    grant_e     last_grant_q;
    logic [7:0] beat_q;
    logic       skp_pending;
    logic       skp_take;

    assign skp_take = (state_q == ST_SKP_COM);

    pcie_symbol_scheduler_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk_i        (CLK_2MHz),
        .rst_n_i      (reset),
        .enb_i        (ENB),
        .skp_take_i   (skp_take),
        .skp_pending_o(skp_pending),
        .skp_overrun_o(skp_overrun)
    );

    always_ff @(posedge CLK_2MHz) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            last_grant_q <= GRANT_DLLP;
        end else if (ENB) begin
            case (state_q)
                ST_IDLE: begin
                    if (skp_pending) begin
                        state_q <= ST_SKP_COM;
                    end else if (tlp_valid && dllp_valid) begin
                        state_q <= (last_grant_q == GRANT_DLLP) ? ST_STP : ST_SDP;
                    end else if (tlp_valid) begin
                        state_q <= ST_STP;
                    end else if (dllp_valid) begin
                        state_q <= ST_SDP;
                    end
                end
                ST_SKP_COM: begin
                    beat_q  <= '0;
                    state_q <= ST_SKP_SKP;
                end
                ST_SKP_SKP: begin
                    beat_q <= beat_q + 8'd1;
                    if (beat_q == SKP_LAST) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STP: begin
                    last_grant_q <= GRANT_TLP;
                    beat_q       <= '0;
                    state_q      <= ST_TLP_DATA;
                end
                ST_TLP_DATA: begin
                    if (tlp_valid) begin
                        beat_q <= beat_q + 8'd1;
                        if (tlp_last) begin
                            state_q <= ST_TLP_END;
                        end else if (beat_q == TLP_LAST) begin
                            state_q <= ST_TLP_EDB;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SDP: begin
                    last_grant_q <= GRANT_DLLP;
                    beat_q       <= '0;
                    state_q      <= ST_DLLP_DATA;
                end
                ST_DLLP_DATA: begin
                    if (dllp_valid) begin
                        beat_q <= beat_q + 8'd1;
                        if (beat_q == DLLP_LAST) begin
                            state_q <= ST_DLLP_END;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        CTRL_SEL   = SEL_IDL;
        tlp_ready  = 1'b0;
        dllp_ready = 1'b0;
        tlp_abort  = 1'b0;
        case (state_q)
            ST_SKP_COM: CTRL_SEL = SEL_COM;
            ST_SKP_SKP: CTRL_SEL = SEL_SKP;
            ST_STP:     CTRL_SEL = SEL_STP;
            ST_SDP:     CTRL_SEL = SEL_SDP;
            ST_TLP_END, ST_DLLP_END: CTRL_SEL = SEL_END;
            ST_TLP_EDB: begin
                CTRL_SEL  = SEL_EDB;
                tlp_abort = 1'b1;
            end
            ST_TLP_DATA: begin
                // A missing beat mid-packet nullifies the TLP on the spot.
                if (tlp_valid) begin
                    CTRL_SEL  = SEL_TLP;
                    tlp_ready = 1'b1;
                end else begin
                    CTRL_SEL  = SEL_EDB;
                    tlp_abort = 1'b1;
                end
            end
            ST_DLLP_DATA: begin
                if (dllp_valid) begin
                    CTRL_SEL   = SEL_TLP;
                    dllp_ready = 1'b1;
                end else begin
                    CTRL_SEL  = SEL_EDB;
                    tlp_abort = 1'b1;
                end
            end
            default: CTRL_SEL = SEL_IDL;
        endcase
        if (!reset || !ENB) begin
            CTRL_SEL   = SEL_IDL;
            tlp_ready  = 1'b0;
            dllp_ready = 1'b0;
            tlp_abort  = 1'b0;
        end
        SYM_K = is_k_sym(CTRL_SEL);
    end

endmodule

// File: tb/tb_pcie_symbol_scheduler.sv
// Self-checking bench for pcie_symbol_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a symbol-queue reference model.
`timescale 1ns/1ps
module tb_pcie_symbol_scheduler;

    localparam int SKP_INTERVAL = 16;
    localparam int SKP_COUNT    = 3;
    localparam int MAX_TLP_LEN  = 16;
    localparam int DLLP_LEN     = 6;

    localparam int C_DAT = 0, C_COM = 1, C_SKP = 3, C_STP = 4, C_SDP = 5;
    localparam int C_END = 6, C_EDB = 7, C_IDL = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ENB = 1'b0;
    logic       tlp_valid = 1'b0;
    logic       tlp_last = 1'b0;
    logic       dllp_valid = 1'b0;
    logic       tlp_ready, dllp_ready, SYM_K, tlp_abort, skp_overrun;
    logic [3:0] CTRL_SEL;

    always #5 clk = ~clk;

    pcie_symbol_scheduler #(
        .SKP_INTERVAL(SKP_INTERVAL),
        .SKP_COUNT   (SKP_COUNT),
        .MAX_TLP_LEN (MAX_TLP_LEN),
        .DLLP_LEN    (DLLP_LEN)
    ) dut (
        .CLK_2MHz   (clk),
        .reset      (reset),
        .ENB        (ENB),
        .tlp_valid  (tlp_valid),
        .tlp_last   (tlp_last),
        .tlp_ready  (tlp_ready),
        .dllp_valid (dllp_valid),
        .dllp_ready (dllp_ready),
        .CTRL_SEL   (CTRL_SEL),
        .SYM_K      (SYM_K),
        .tlp_abort  (tlp_abort),
        .skp_overrun(skp_overrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of framing/ordered-set symbols still to emit, plus an open data phase.
    int fixq[$];
    int data_src;      // 0 none, 1 TLP, 2 DLLP
    int data_n;
    int tmr;
    bit pend, ovr, last_tlp;
    int e_sel;
    bit e_trdy, e_drdy, e_abort;

    // Traffic sources.
    int tlp_rem, tlp_sent, tlp_gap_at, dllp_rem;
    bit tlp_hold, dllp_hold;

    int kc;
    int sel_rec[64];
    int trdy_rec[64];
    int drdy_rec[64];
    int abort_rec[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, kc);
        end
    endtask

    task automatic drive_sources();
        tlp_valid  = (tlp_rem > 0) && (tlp_sent != tlp_gap_at) && !tlp_hold;
        tlp_last   = (tlp_rem == 1);
        dllp_valid = (dllp_rem > 0) && !dllp_hold;
    endtask

    task automatic model_outputs();
        e_sel   = C_IDL;
        e_trdy  = 1'b0;
        e_drdy  = 1'b0;
        e_abort = 1'b0;
        if (reset && ENB) begin
            if (fixq.size() > 0) begin
                e_sel   = fixq[0];
                e_abort = (e_sel == C_EDB);
            end else if (data_src == 1) begin
                if (tlp_valid) begin e_sel = C_DAT; e_trdy = 1'b1; end
                else begin e_sel = C_EDB; e_abort = 1'b1; end
            end else if (data_src == 2) begin
                if (dllp_valid) begin e_sel = C_DAT; e_drdy = 1'b1; end
                else begin e_sel = C_EDB; e_abort = 1'b1; end
            end
        end
    endtask

    task automatic model_step();
        bit old_pend;
        bit took;
        int s;
        if (!reset) begin
            fixq.delete();
            data_src = 0; data_n = 0; tmr = 0;
            pend = 0; ovr = 0; last_tlp = 0;
        end else if (ENB) begin
            old_pend = pend;
            took = 0;
            if (fixq.size() > 0) begin
                s = fixq.pop_front();
                if (s == C_STP) begin data_src = 1; data_n = 0; last_tlp = 1; end
                else if (s == C_SDP) begin data_src = 2; data_n = 0; last_tlp = 0; end
                else if (s == C_COM) took = 1;
            end else if (data_src == 1) begin
                if (tlp_valid) begin
                    data_n++;
                    if (tlp_last) begin fixq.push_back(C_END); data_src = 0; end
                    else if (data_n == MAX_TLP_LEN) begin fixq.push_back(C_EDB); data_src = 0; end
                end else data_src = 0;
            end else if (data_src == 2) begin
                if (dllp_valid) begin
                    data_n++;
                    if (data_n == DLLP_LEN) begin fixq.push_back(C_END); data_src = 0; end
                end else data_src = 0;
            end else begin
                if (old_pend) begin
                    fixq.push_back(C_COM);
                    repeat (SKP_COUNT) fixq.push_back(C_SKP);
                end else if (tlp_valid && dllp_valid) fixq.push_back(last_tlp ? C_SDP : C_STP);
                else if (tlp_valid) fixq.push_back(C_STP);
                else if (dllp_valid) fixq.push_back(C_SDP);
            end
            if (tmr == SKP_INTERVAL - 1) begin
                tmr = 0;
                if (old_pend) ovr = 1;
                pend = 1;
            end else begin
                tmr++;
                if (took) pend = 0;
            end
        end
    endtask

    task automatic source_step();
        if (tlp_valid && e_trdy) begin
            tlp_rem--; tlp_sent++;
            if (tlp_rem == 0) tlp_sent = 0;
        end
        if (dllp_valid && e_drdy) dllp_rem--;
    endtask

    task automatic cyc();
        drive_sources();
        @(negedge clk);
        model_outputs();
        chk("ctrl_sel", CTRL_SEL, e_sel);
        chk("sym_k", SYM_K, (e_sel != C_DAT));
        chk("tlp_ready", tlp_ready, e_trdy);
        chk("dllp_ready", dllp_ready, e_drdy);
        chk("tlp_abort", tlp_abort, e_abort);
        chk("skp_overrun", skp_overrun, ovr);
        if (kc < 64) begin
            sel_rec[kc] = e_sel;
            trdy_rec[kc] = int'(tlp_ready);
            drdy_rec[kc] = int'(dllp_ready);
            abort_rec[kc] = int'(tlp_abort);
        end
        kc++;
        @(posedge clk);
        model_step();
        source_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; ENB = 1'b1;
        tlp_rem = 0; tlp_sent = 0; tlp_gap_at = -1; dllp_rem = 0;
        tlp_hold = 0; dllp_hold = 0;
        cyc(); cyc();
        chk("rst_sel", CTRL_SEL, C_IDL);
        chk("rst_symk", SYM_K, 1);
        chk("rst_readies", {tlp_ready, dllp_ready, tlp_abort}, 0);
        chk("rst_overrun", skp_overrun, 0);
        reset = 1'b1;
        kc = 0;
    endtask

    initial begin
        int n;
        tlp_gap_at = -1;
        kc = 0;

        // 1: idle link, SKP ordered sets every 16 cycles
        do_reset();
        repeat (40) cyc();
        chk("t1_idl16", sel_rec[16], C_IDL);
        chk("t1_com17", sel_rec[17], C_COM);
        for (int i = 18; i <= 20; i++) chk("t1_skp", sel_rec[i], C_SKP);
        chk("t1_idl21", sel_rec[21], C_IDL);
        chk("t1_com33", sel_rec[33], C_COM);
        chk("t1_overrun", skp_overrun, 0);

        // 2: 4-beat TLP
        do_reset();
        tlp_rem = 4;
        repeat (8) cyc();
        chk("t2_stp", sel_rec[1], C_STP);
        for (int i = 2; i <= 5; i++) chk("t2_data", sel_rec[i], C_DAT);
        chk("t2_end", sel_rec[6], C_END);
        n = 0;
        for (int i = 0; i < 8; i++) n += trdy_rec[i];
        chk("t2_ready_cycles", n, 4);

        // 3: repeated TLP/DLLP ties alternate starting with TLP
        do_reset();
        tlp_rem = 3; dllp_rem = 6;
        for (int i = 0; i < 17; i++) begin
            if (tlp_rem == 0) tlp_rem = 3;
            if (dllp_rem == 0) dllp_rem = 6;
            cyc();
        end
        tlp_rem = 0; dllp_rem = 0;
        chk("t3_first_stp", sel_rec[1], C_STP);
        chk("t3_sdp", sel_rec[7], C_SDP);
        chk("t3_dllp_end", sel_rec[14], C_END);
        chk("t3_third_stp", sel_rec[16], C_STP);

        // 4a: source gap after 2 beats
        do_reset();
        tlp_rem = 5; tlp_gap_at = 2;
        repeat (8) cyc();
        chk("t4_edb", sel_rec[4], C_EDB);
        chk("t4_abort", abort_rec[4], 1);
        n = 0;
        for (int i = 0; i < 8; i++) n += abort_rec[i];
        chk("t4_abort_pulses", n, 1);
        chk("t4_idl", sel_rec[5], C_IDL);
        tlp_gap_at = -1; tlp_rem = 0; tlp_sent = 0;

        // 4b: 20-beat TLP cut at MAX_TLP_LEN
        do_reset();
        tlp_rem = 20;
        repeat (20) cyc();
        n = 0;
        for (int i = 2; i <= 17; i++) n += (sel_rec[i] == C_DAT) ? 1 : 0;
        chk("t4_maxlen_beats", n, 16);
        chk("t4_maxlen_edb", sel_rec[18], C_EDB);
        tlp_rem = 0; tlp_sent = 0;

        // 5: SKP request during a TLP waits for END
        do_reset();
        repeat (6) cyc();
        tlp_rem = 12;
        repeat (20) cyc();
        chk("t5_end", sel_rec[20], C_END);
        chk("t5_idl", sel_rec[21], C_IDL);
        chk("t5_com", sel_rec[22], C_COM);
        for (int i = 23; i <= 25; i++) chk("t5_skp", sel_rec[i], C_SKP);

        // 6a: ENB stall mid-TLP
        do_reset();
        tlp_rem = 6;
        repeat (4) cyc();
        ENB = 1'b0;
        repeat (3) cyc();
        ENB = 1'b1;
        repeat (6) cyc();
        chk("t6_stall_sel", sel_rec[5], C_IDL);
        chk("t6_stall_ready", trdy_rec[5], 0);
        chk("t6_resume", sel_rec[7], C_DAT);
        chk("t6_end", sel_rec[11], C_END);

        // 6b: reset mid-DLLP drops the frame
        do_reset();
        dllp_rem = 6;
        repeat (4) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        chk("t6_rst_sel", sel_rec[4], C_IDL);
        chk("t6_rst_ready", drdy_rec[4], 0);
        chk("t6_no_end", sel_rec[5], C_IDL);
        chk("t6_new_sdp", sel_rec[6], C_SDP);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            ENB = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 599) != 0);
            if (tlp_rem == 0 && $urandom_range(0, 5) == 0) begin
                tlp_rem = $urandom_range(1, 20);
                tlp_sent = 0;
            end
            if (dllp_rem == 0 && $urandom_range(0, 5) == 0)
                dllp_rem = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : DLLP_LEN;
            tlp_hold = ($urandom_range(0, 29) == 0);
            dllp_hold = ($urandom_range(0, 29) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
